// File: rtl/ioctl_loader_pkg.sv
// Shared types and helpers for the ioctl word loader.
package ioctl_loader_pkg;

  localparam int CHK_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    WRITE,
    FLUSH,
    DONE
  } state_e;

  // Bit offset of a byte lane inside an nbytes-wide word.
  function automatic int lane_shift(
    input int lane,
    input bit big_endian,
    input int nbytes
  );
    return big_endian ? 8 * (nbytes - 1 - lane) : 8 * lane;
  endfunction

endpackage

// File: rtl/ioctl_skid_buf.sv
// Single-entry byte/address holding register.
module ioctl_skid_buf #(
  parameter int AW = 25
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          load,
  input  logic [AW-1:0] addr_in,
  input  logic [7:0]    data_in,
  input  logic          take,
  output logic          valid,
  output logic [AW-1:0] addr_out,
  output logic [7:0]    data_out
);

  logic          valid_q, valid_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (take) valid_d = 1'b0;
    if (load) begin
      valid_d = 1'b1;
      addr_d  = addr_in;
      data_d  = data_in;
    end
    if (clr) valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign valid    = valid_q;
  assign addr_out = addr_q;
  assign data_out = data_q;

endmodule

// File: rtl/ioctl_word_loader.sv
// Packs the hps_io ioctl byte stream into memory words with backpressure.
module ioctl_word_loader
  import ioctl_loader_pkg::*;
#(
  parameter int          WORD_BYTES = 2,
  parameter int          ADDR_W     = 15,
  parameter bit          BIG_ENDIAN = 1'b1,
  parameter logic [7:0]  PAD_BYTE   = 8'h00
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  input  logic                    ioctl_download,
  input  logic                    ioctl_wr,
  input  logic [24:0]             ioctl_addr,
  input  logic [7:0]              ioctl_dout,
  output logic                    ioctl_wait,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [8*WORD_BYTES-1:0] mem_data,
  output logic                    mem_wr,
  input  logic                    mem_ready,
  output logic [ADDR_W:0]         words_loaded,
  output logic [CHK_W-1:0]        checksum,
  output logic                    done,
  output logic                    overflow
);

  localparam int               W        = 8 * WORD_BYTES;
  localparam int               WL_W     = ADDR_W + 1;
  localparam logic [W-1:0]     PAD_WORD = {WORD_BYTES{PAD_BYTE}};
  localparam logic [24:0]      WB25     = 25'(WORD_BYTES);

  state_e              state_q, state_d;
  logic                dl_q;
  logic [W-1:0]        word_q, word_d;
  logic                dirty_q, dirty_d;
  logic [24:0]         last_q, last_d;
  logic [ADDR_W-1:0]   maddr_q, maddr_d;
  logic [W-1:0]        mdata_q, mdata_d;
  logic                mwr_q, mwr_d;
  logic                wait_q, wait_d;
  logic [WL_W-1:0]     words_q, words_d;
  logic [CHK_W-1:0]    chk_q, chk_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;

  logic        rise, in_collect, take, acc, skid_load;
  logic        skid_valid;
  logic [24:0] skid_addr, b_addr, lane_w, idx;
  logic [7:0]  skid_data, b_data;
  logic [W-1:0] merged;
  int          sh;

  assign rise       = ioctl_download & ~dl_q;
  assign in_collect = (state_q == COLLECT) && !rise;
  assign take       = in_collect && skid_valid;
  assign acc        = take || (in_collect && ioctl_wr);
  assign b_addr     = take ? skid_addr : ioctl_addr;
  assign b_data     = take ? skid_data : ioctl_dout;
  assign lane_w     = b_addr % WB25;
  assign idx        = b_addr / WB25;
  assign sh         = lane_shift(int'(lane_w), BIG_ENDIAN, WORD_BYTES);
  assign merged     = (word_q & ~(W'(8'hFF) << sh)) | (W'(b_data) << sh);

  // Writes landing during the one-cycle wait latency park in the skid.
  assign skid_load = ioctl_wr && !rise &&
    ((((state_q == WRITE) || (state_q == FLUSH)) && !skid_valid) || take);

  ioctl_skid_buf #(.AW(25)) u_skid (
    .clk      (clk_sys),
    .rst_n    (reset_n),
    .clr      (rise),
    .load     (skid_load),
    .addr_in  (ioctl_addr),
    .data_in  (ioctl_dout),
    .take     (take),
    .valid    (skid_valid),
    .addr_out (skid_addr),
    .data_out (skid_data)
  );

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    dirty_d = dirty_q;
    last_d  = last_q;
    maddr_d = maddr_q;
    mdata_d = mdata_q;
    mwr_d   = mwr_q;
    words_d = words_q;
    chk_d   = chk_q;
    done_d  = done_q;
    ovf_d   = ovf_q;
    if (rise) begin
      state_d = COLLECT;
      word_d  = PAD_WORD;
      dirty_d = 1'b0;
      mwr_d   = 1'b0;
      words_d = '0;
      chk_d   = '0;
      done_d  = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state_q)
        COLLECT: begin
          if (acc) begin
            chk_d   = chk_q + CHK_W'(b_data);
            dirty_d = 1'b1;
            last_d  = idx;
            word_d  = merged;
            if (lane_w == WB25 - 25'd1) begin
              if ((idx >> ADDR_W) == '0) begin
                maddr_d = idx[ADDR_W-1:0];
                mdata_d = merged;
                mwr_d   = 1'b1;
                state_d = WRITE;
              end else begin
                ovf_d   = 1'b1;
                word_d  = PAD_WORD;
                dirty_d = 1'b0;
              end
            end
          end else if (!ioctl_download) begin
            state_d = DONE;
            done_d  = 1'b1;
            if (dirty_q) begin
              if ((last_q >> ADDR_W) == '0) begin
                maddr_d = last_q[ADDR_W-1:0];
                mdata_d = word_q;
                mwr_d   = 1'b1;
                state_d = FLUSH;
                done_d  = 1'b0;
              end else begin
                ovf_d   = 1'b1;
                word_d  = PAD_WORD;
                dirty_d = 1'b0;
              end
            end
          end
        end
        WRITE, FLUSH: begin
          if (mem_ready) begin
            words_d = words_q + WL_W'(1);
            word_d  = PAD_WORD;
            dirty_d = 1'b0;
            mwr_d   = 1'b0;
            if (state_q == FLUSH) begin
              state_d = DONE;
              done_d  = 1'b1;
            end else begin
              state_d = COLLECT;
            end
          end
        end
        default: ;
      endcase
    end
    wait_d = (state_d == WRITE) || (state_d == FLUSH);
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q <= IDLE;
      dl_q    <= 1'b0;
      word_q  <= PAD_WORD;
      dirty_q <= 1'b0;
      last_q  <= '0;
      maddr_q <= '0;
      mdata_q <= '0;
      mwr_q   <= 1'b0;
      wait_q  <= 1'b0;
      words_q <= '0;
      chk_q   <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dl_q    <= ioctl_download;
      word_q  <= word_d;
      dirty_q <= dirty_d;
      last_q  <= last_d;
      maddr_q <= maddr_d;
      mdata_q <= mdata_d;
      mwr_q   <= mwr_d;
      wait_q  <= wait_d;
      words_q <= words_d;
      chk_q   <= chk_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ioctl_wait   = wait_q;
  assign mem_addr     = maddr_q;
  assign mem_data     = mdata_q;
  assign mem_wr       = mwr_q & ~rise;
  assign words_loaded = words_q;
  assign checksum     = chk_q;
  assign done         = done_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_ioctl_word_loader.sv
// Bench for ioctl_word_loader: three configurations, scoreboarded writes.
module tb_ioctl_word_loader;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  dl = '0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        mem_ready = 1'b1;

  logic        w0, mw0, dn0, ov0;
  logic [14:0] ma0;
  logic [15:0] md0, wl0, ck0;
  logic        w1, mw1, dn1, ov1;
  logic [14:0] ma1;
  logic [31:0] md1;
  logic [15:0] wl1, ck1;
  logic        w2, mw2, dn2, ov2;
  logic [1:0]  ma2;
  logic [15:0] md2, ck2;
  logic [2:0]  wl2;

  always #5 clk = ~clk;

  ioctl_word_loader u_dut0 (
    .clk_sys(clk), .reset_n(reset_n), .ioctl_download(dl[0]),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(w0), .mem_addr(ma0), .mem_data(md0), .mem_wr(mw0),
    .mem_ready(mem_ready), .words_loaded(wl0), .checksum(ck0),
    .done(dn0), .overflow(ov0)
  );

  ioctl_word_loader #(.WORD_BYTES(4), .BIG_ENDIAN(1'b0)) u_dut1 (
    .clk_sys(clk), .reset_n(reset_n), .ioctl_download(dl[1]),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(w1), .mem_addr(ma1), .mem_data(md1), .mem_wr(mw1),
    .mem_ready(mem_ready), .words_loaded(wl1), .checksum(ck1),
    .done(dn1), .overflow(ov1)
  );

  ioctl_word_loader #(.ADDR_W(2)) u_dut2 (
    .clk_sys(clk), .reset_n(reset_n), .ioctl_download(dl[2]),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
    .ioctl_wait(w2), .mem_addr(ma2), .mem_data(md2), .mem_wr(mw2),
    .mem_ready(mem_ready), .words_loaded(wl2), .checksum(ck2),
    .done(dn2), .overflow(ov2)
  );

  typedef struct {
    int unsigned addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int          n;
    logic [31:0] bytes;
    int          nw;
    logic [31:0] words;
    logic [15:0] chk;
  } vec_t;

  wr_t  q0[$], q1[$], q2[$];
  vec_t tbl[4];
  int   checks = 0;
  int   errors = 0;
  int   sel = 0;
  int   pulses0 = 0;
  logic w0_prev = 1'b0;
  logic wr_in_wait = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_pop(input int id, input logic [31:0] a,
                        input logic [31:0] d);
    wr_t e;
    int  sz;
    sz = (id == 0) ? q0.size() : (id == 1) ? q1.size() : q2.size();
    checks++;
    if (sz == 0) begin
      errors++;
      $display("FAIL sb%0d unexpected write: addr %0h data %0h", id, a, d);
      return;
    end
    case (id)
      0: e = q0.pop_front();
      1: e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
    if (e.addr !== a || e.data !== d) begin
      errors++;
      $display("FAIL sb%0d write: got %0h@%0h expected %0h@%0h",
               id, d, a, e.data, e.addr);
    end
  endtask

  always @(negedge clk) if (mw0 && mem_ready) sb_pop(0, 32'(ma0), 32'(md0));
  always @(negedge clk) if (mw1 && mem_ready) sb_pop(1, 32'(ma1), md1);
  always @(negedge clk) if (mw2 && mem_ready) sb_pop(2, 32'(ma2), 32'(md2));

  function automatic logic wsel();
    case (sel)
      0: return w0;
      1: return w1;
      default: return w2;
    endcase
  endfunction

  always @(negedge clk) begin
    if (w0 && !w0_prev) pulses0++;
    w0_prev = w0;
    if (ioctl_wr && wsel()) begin
      if (wr_in_wait) begin
        errors++;
        $display("FAIL protocol: second ioctl_wr while skid full");
      end
      wr_in_wait = 1'b1;
    end else if (!wsel()) begin
      wr_in_wait = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(input int a, input logic [7:0] d);
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'(a);
    ioctl_dout = d;
    tick();
    ioctl_wr = 1'b0;
  endtask

  task automatic send_byte(input int a, input logic [7:0] d);
    int n;
    drive_wr(a, d);
    n = 0;
    while (wsel() && n < 100) begin
      tick();
      n++;
    end
    if (n == 100) begin
      checks++;
      errors++;
      $display("FAIL wait_timeout: ioctl_wait stuck at addr %0d", a);
    end
  endtask

  task automatic start_dl(input int id);
    sel     = id;
    dl[id]  = 1'b1;
    pulses0 = 0;
    tick();
    tick();
  endtask

  task automatic end_dl(input int id);
    int  n;
    logic d;
    dl[id] = 1'b0;
    n = 0;
    d = 1'b0;
    while (!d && n < 200) begin
      tick();
      n++;
      d = (id == 0) ? dn0 : (id == 1) ? dn1 : dn2;
    end
    checks++;
    if (!d) begin
      errors++;
      $display("FAIL done_timeout: dut%0d done=0 expected 1", id);
    end
  endtask

  initial begin
    tbl[0] = '{4, 32'h12345678, 2, 32'h12345678, 16'h0114};
    tbl[1] = '{3, 32'hAABBCC00, 2, 32'hAABBCC00, 16'h0231};
    tbl[2] = '{1, 32'h5A000000, 1, 32'h5A000000, 16'h005A};
    tbl[3] = '{2, 32'hFFFF0000, 1, 32'hFFFF0000, 16'h01FE};

    repeat (3) tick();
    check("rst_mem_wr", 32'(mw0), 0);
    check("rst_wait", 32'(w0), 0);
    check("rst_done", 32'(dn0), 0);
    check("rst_words", 32'(wl0), 0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < tbl[i].nw; j++)
        q0.push_back('{j, 32'(tbl[i].words[16*(1-j) +: 16])});
      start_dl(0);
      for (int j = 0; j < tbl[i].n; j++)
        send_byte(j, tbl[i].bytes[8*(3-j) +: 8]);
      end_dl(0);
      check($sformatf("v%0d_words", i), 32'(wl0), 32'(tbl[i].nw));
      check($sformatf("v%0d_chk", i), 32'(ck0), 32'(tbl[i].chk));
      check($sformatf("v%0d_pulses", i), 32'(pulses0), 32'(tbl[i].nw));
      check($sformatf("v%0d_ovf", i), 32'(ov0), 0);
      check($sformatf("v%0d_q", i), 32'(q0.size()), 0);
    end

    q1.push_back('{0, 32'h04030201});
    start_dl(1);
    for (int j = 0; j < 4; j++) send_byte(j, 8'(j + 1));
    end_dl(1);
    check("le32_words", 32'(wl1), 1);
    check("le32_chk", 32'(ck1), 32'h0A);
    check("le32_q", 32'(q1.size()), 0);

    q0.push_back('{0, 32'h1122});
    q0.push_back('{1, 32'h3344});
    start_dl(0);
    mem_ready = 1'b0;
    drive_wr(0, 8'h11);
    drive_wr(1, 8'h22);
    drive_wr(2, 8'h33);
    for (int k = 0; k < 5; k++) begin
      check("bp_wait", 32'(w0), 1);
      check("bp_addr", 32'(ma0), 0);
      check("bp_data", 32'(md0), 32'h1122);
      tick();
    end
    mem_ready = 1'b1;
    tick();
    tick();
    send_byte(3, 8'h44);
    end_dl(0);
    check("bp_words", 32'(wl0), 2);
    check("bp_chk", 32'(ck0), 32'h00AA);
    check("bp_q", 32'(q0.size()), 0);

    for (int j = 0; j < 4; j++)
      q2.push_back('{j, {16'h0, 8'(2*j + 1), 8'(2*j + 2)}});
    start_dl(2);
    for (int j = 0; j < 10; j++) send_byte(j, 8'(j + 1));
    end_dl(2);
    check("ovf_flag", 32'(ov2), 1);
    check("ovf_words", 32'(wl2), 4);
    check("ovf_q", 32'(q2.size()), 0);

    start_dl(0);
    mem_ready = 1'b0;
    drive_wr(0, 8'hAB);
    drive_wr(1, 8'hCD);
    check("rw_pending", 32'(mw0), 1);
    reset_n = 1'b0;
    dl[0]   = 1'b0;
    tick();
    check("rw_mem_wr", 32'(mw0), 0);
    check("rw_addr", 32'(ma0), 0);
    check("rw_data", 32'(md0), 0);
    check("rw_wait", 32'(w0), 0);
    check("rw_words", 32'(wl0), 0);
    check("rw_chk", 32'(ck0), 0);
    check("rw_done", 32'(dn0), 0);
    check("rw_ovf", 32'(ov0), 0);
    reset_n   = 1'b1;
    mem_ready = 1'b1;
    tick();
    q0.push_back('{0, 32'h0001});
    start_dl(0);
    send_byte(0, 8'h00);
    send_byte(1, 8'h01);
    end_dl(0);
    check("rw2_words", 32'(wl0), 1);
    check("rw2_chk", 32'(ck0), 1);
    check("rw2_q", 32'(q0.size()), 0);

    tick();
    check("final_q", 32'(q0.size() + q1.size() + q2.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
